// File: rtl/clk_pwr_pkg.sv
// Purpose : shared state encoding, output bundle and default timing constants for clk_pwr_seq.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package clk_pwr_pkg;

   localparam int unsigned SETTLE_CYCLES_DEF = 16;
   localparam int unsigned SLEEP_DELAY_DEF   = 64;
   localparam int unsigned LOCK_TIMEOUT_DEF  = 4096;
   localparam int unsigned CNT_W_DEF         = 16;

   typedef enum logic [2:0] {
      ST_RELOCK   = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_RUN      = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_GATED    = 3'd4,
      ST_PLL_OFF  = 3'd5,
      ST_FALLBACK = 3'd6
   } state_t;

   typedef struct packed {
      logic pll_resetb;
      logic sel_pll;
      logic core_clk_en;
      logic sleeping;
   } pwr_out_t;

   // Output decode for a given (next) state. fb_gated selects the sleeping
   // half of FALLBACK, where the core runs on the reference clock.
   function automatic pwr_out_t decode_out(input state_t st, input logic fb_gated);
      pwr_out_t o;
      o = '{pll_resetb: 1'b1, sel_pll: 1'b0, core_clk_en: 1'b0, sleeping: 1'b0};
      case (st)
         ST_RUN, ST_DRAIN: begin
            o.sel_pll     = 1'b1;
            o.core_clk_en = 1'b1;
         end
         ST_GATED: begin
            // PLL stays locked and selected so a wake only re-enables the gate.
            o.sel_pll  = 1'b1;
            o.sleeping = 1'b1;
         end
         ST_PLL_OFF: begin
            o.pll_resetb = 1'b0;
            o.sleeping   = 1'b1;
         end
         ST_FALLBACK: begin
            // PLL gave up on: keep it powered down until reset.
            o.pll_resetb  = 1'b0;
            o.core_clk_en = ~fb_gated;
            o.sleeping    = fb_gated;
         end
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/clk_pwr_seq_sync2.sv
// Purpose : 2-flop synchroniser bringing pll_lock into the clk domain.
// Latency : 2 clk cycles from d to q.
// Backpressure: none; level signal, sampled every cycle.
// Ports   : clk, reset (sync, active-high, clears both flops), d (async in), q (synchronised out).
module clk_pwr_seq_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_pwr_seq.sv
// Purpose : core clock / PLL power sequencer (relock, settle, run, drain, gate, PLL off, fallback).
// Latency : outputs registered, decoded from next state (1 cycle after the deciding input; pll_lock +2 for sync).
// Backpressure: mem_busy holds DRAIN so the clock is never gated mid memory stall.
// Ports   : clk, reset (sync, active-high); wfi, wake, mem_busy, pll_lock in;
//           pll_resetb, sel_pll, core_clk_en, sleeping, lock_err (sticky) out.
module clk_pwr_seq
   import clk_pwr_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int unsigned SLEEP_DELAY   = SLEEP_DELAY_DEF,
   parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic wfi,
   input  logic wake,
   input  logic mem_busy,
   input  logic pll_lock,
   output logic pll_resetb,
   output logic sel_pll,
   output logic core_clk_en,
   output logic sleeping,
   output logic lock_err
);

   // A timer "reaches" N on the N-th cycle spent in the state, i.e. when the
   // count of cycles already spent there is N-1.
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLEEP_LAST  = CNT_W'(SLEEP_DELAY - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             fb_gated_q, fb_gated_d;
   logic             set_err;
   logic             lock_s;
   pwr_out_t         out_q, out_d;

   clk_pwr_seq_sync2 u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // Saturating increment: a long stay never wraps back into a timeout window.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      fb_gated_d = fb_gated_q;
      set_err    = 1'b0;
      case (state_q)
         ST_RELOCK: begin
            if (lock_s) begin
               state_d = ST_SETTLE;
            end else if (cnt_q >= LOCK_LAST) begin
               state_d = ST_FALLBACK;
               set_err = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (!lock_s)                    state_d = ST_RELOCK;
            else if (cnt_q >= SETTLE_LAST)  state_d = ST_RUN;
         end
         ST_RUN: begin
            // Lock loss outranks a sleep request.
            if (!lock_s)                    state_d = ST_RELOCK;
            else if (wfi && !wake)          state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Still clocked from the PLL here, so lock loss is handled as in RUN.
            if (!lock_s)                    state_d = ST_RELOCK;
            else if (wake || !wfi)          state_d = ST_RUN;
            else if (!mem_busy)             state_d = ST_GATED;
         end
         ST_GATED: begin
            // Wake outranks the power-down timer; a lock lost while asleep
            // resumes through RELOCK rather than clocking the core off a bad PLL.
            if (wake)                       state_d = lock_s ? ST_RUN : ST_RELOCK;
            else if (cnt_q >= SLEEP_LAST)   state_d = ST_PLL_OFF;
         end
         ST_PLL_OFF: begin
            if (wake)                       state_d = ST_RELOCK;
         end
         ST_FALLBACK: begin
            // Terminal until reset; only the core gate toggles.
            if (fb_gated_q) begin
               if (wake)                    fb_gated_d = 1'b0;
            end else if (wfi && !wake) begin
               fb_gated_d = 1'b1;
            end
         end
         default:                           state_d = ST_RELOCK;
      endcase

      cnt_d = (state_d != state_q) ? '0 : cnt_inc;
      out_d = decode_out(state_d, fb_gated_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RELOCK;
         cnt_q      <= '0;
         fb_gated_q <= 1'b0;
         out_q      <= '{pll_resetb: 1'b1, sel_pll: 1'b0, core_clk_en: 1'b0, sleeping: 1'b0};
         lock_err   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fb_gated_q <= fb_gated_d;
         out_q      <= out_d;
         lock_err   <= lock_err | set_err;
      end
   end

   assign pll_resetb  = out_q.pll_resetb;
   assign sel_pll     = out_q.sel_pll;
   assign core_clk_en = out_q.core_clk_en;
   assign sleeping    = out_q.sleeping;

endmodule

// File: doc/clk_pwr_seq.md
CLK_PWR_SEQ -- requirements
Module: clk_pwr_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: consecutive locked cycles required before switching the core to the PLL.
REQ-002 SHALL have parameter SLEEP_DELAY, default 64: gated cycles before the PLL is powered down.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed for pll_lock before declaring failure.
REQ-004 SHALL have parameter CNT_W, default 16: counter width; all parameter values SHALL fit in CNT_W bits.
REQ-005 SHALL have port clk, input, 1: free-running reference clock (48 MHz HFOSC). One clock only.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port wfi, input, 1: CPU requests sleep.
REQ-008 SHALL have port wake, input, 1: pending wake event (interrupt/LED-write request).
REQ-009 SHALL have port mem_busy, input, 1: data memory stall in progress.
REQ-010 SHALL have port pll_lock, input, 1: PLL lock indicator; the block SHALL synchronise it through 2 flops.
REQ-011 SHALL have port pll_resetb, output, 1: PLL enable (0 holds the PLL in reset/powered down).
REQ-012 SHALL have port sel_pll, output, 1: glitch-free mux select (1 = PLL clock, 0 = reference clock).
REQ-013 SHALL have port core_clk_en, output, 1: core clock-gate enable.
REQ-014 SHALL have port sleeping, output, 1: core clock gated.
REQ-015 SHALL have port lock_err, output, 1: sticky lock-timeout flag.

Function
REQ-016 SHALL implement the FSM states RELOCK, SETTLE, RUN, DRAIN, GATED, PLL_OFF and FALLBACK; all outputs SHALL be registered and decoded from the next state.
REQ-017 RELOCK: pll_resetb=1, sel_pll=0, core_clk_en=0; synchronised lock -> SETTLE; timer reaching LOCK_TIMEOUT -> FALLBACK and lock_err=1.
REQ-018 SETTLE: counts locked cycles; lock deasserting -> RELOCK with the counter cleared; count reaching SETTLE_CYCLES -> RUN.
REQ-019 RUN: sel_pll=1, core_clk_en=1.
REQ-020 RUN: wfi=1 and wake=0 -> DRAIN.
REQ-021 RUN: lock lost -> RELOCK; core_clk_en and sel_pll SHALL drop on the same edge.
REQ-022 DRAIN: core_clk_en=1; wake=1 or wfi=0 -> RUN; else mem_busy=0 -> GATED. DRAIN SHALL never gate the clock while mem_busy=1.
REQ-023 GATED: core_clk_en=0, sleeping=1, PLL still on; wake=1 -> RUN in 1 cycle.
REQ-024 GATED: timer reaching SLEEP_DELAY -> PLL_OFF.
REQ-025 PLL_OFF: pll_resetb=0, sel_pll=0, sleeping=1; wake=1 -> RELOCK.
REQ-026 FALLBACK: sel_pll=0 and core_clk_en=1, so the core runs on the reference clock.
REQ-027 FALLBACK: wfi=1 with wake=0 SHALL gate the core (core_clk_en=0, sleeping=1) until wake=1; the PLL SHALL NOT be retried until reset.
REQ-028 Simultaneous events: wake SHALL have priority over the timer expiring in GATED.
REQ-029 Simultaneous events: lock loss SHALL have priority over wfi in RUN.
REQ-030 Timers SHALL saturate, never wrap, and SHALL clear on every state change.
REQ-031 sel_pll SHALL change only while core_clk_en=0 or in the same cycle it falls; no sel_pll 0->1 transition SHALL occur with core_clk_en=1.

Reset
REQ-032 reset SHALL force state RELOCK, timers to 0 and the lock synchroniser to 0.
REQ-033 On reset the outputs SHALL be pll_resetb=1, sel_pll=0, core_clk_en=0, sleeping=0, lock_err=0.
REQ-034 reset asserted mid-sequence (any state) SHALL take effect on the next edge; lock_err SHALL be cleared only by reset.

Structure
REQ-035 State encoding and the default parameter constants SHALL live in shared package clk_pwr_pkg.
REQ-036 Only one sub-module is natural: sync2 (2-flop synchroniser for pll_lock).
REQ-037 The block SHALL be instantiated in top alongside pll_ctrl, driven by clk_ref, with mem_busy=data_clk_stall.

Verification (SETTLE_CYCLES=8, SLEEP_DELAY=16, LOCK_TIMEOUT=100)
REQ-038 Boot scenario: reset 3 cycles, lock rising at cycle 10 -> sel_pll=1 and core_clk_en=1 at cycle 10+2+8 (+/-1); lock_err=0.
REQ-039 Drain scenario: wfi=1 with mem_busy=1 for 5 cycles -> core_clk_en stays 1 through those 5 cycles; it falls 1 cycle after mem_busy=0.
REQ-040 Short-sleep scenario: wake at gated cycle 10 -> RUN next cycle; pll_resetb never dropped.
REQ-041 Deep-sleep scenario: no wake for 16 gated cycles -> pll_resetb=0.
REQ-042 Deep-sleep wake scenario: wake after pll_resetb=0 -> RELOCK/SETTLE, then RUN.
REQ-043 Timeout scenario: pll_lock tied to 0 -> lock_err=1 at cycle ~100; core_clk_en=1, sel_pll=0; then wfi gates the core and wake restores it; lock_err stays 1.
REQ-044 Glitch scenario: pll_lock drops for 1 synchronised cycle in RUN -> core_clk_en=0 and sel_pll=0 on the same edge, followed by the full SETTLE_CYCLES re-settle.
